// File: rtl/mips_div_ctrl.sv
// Sequencer for the radix-4 multicycle divider datapath: latches operand magnitudes,
// steps the datapath STEPS times, then captures the sign-corrected quotient/remainder.
module mips_div_ctrl #(
    parameter int unsigned STEPS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        dp_acompl,
    output logic        dp_bcompl,
    output logic        dp_ready,
    output logic [31:0] dp_a,
    output logic [31:0] dp_b,
    output logic [31:0] dp_rem,
    input  logic [31:0] dp_quotient,
    input  logic [31:0] dp_remainder
);

    localparam logic [3:0] LastStep = 4'(STEPS - 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e      state;
    logic [31:0] a_reg, b_reg, r_reg;
    logic        acompl_q, bcompl_q;
    logic [3:0]  cnt;
    logic        zero_pend;

    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;

    // 0x80000000 negates to itself, which is the correct unsigned magnitude.
    always_comb begin
        a_neg = is_signed & op_a[31];
        b_neg = is_signed & op_b[31];
        a_mag = a_neg ? (~op_a + 32'd1) : op_a;
        b_mag = b_neg ? (~op_b + 32'd1) : op_b;
    end

    assign dp_a      = a_reg;
    assign dp_b      = b_reg;
    assign dp_rem    = r_reg;
    assign dp_acompl = acompl_q;
    assign dp_bcompl = bcompl_q;
    assign dp_ready  = (state == StRun) && (cnt == LastStep);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            r_reg     <= '0;
            acompl_q  <= 1'b0;
            bcompl_q  <= 1'b0;
            cnt       <= '0;
            zero_pend <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start && !abort) begin
                        acompl_q  <= a_neg;
                        bcompl_q  <= b_neg;
                        a_reg     <= a_mag;
                        b_reg     <= b_mag;
                        r_reg     <= '0;
                        cnt       <= '0;
                        zero_pend <= (op_b == 32'd0);
                        busy      <= 1'b1;
                        state     <= StRun;
                    end
                end
                StRun: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= StIdle;
                    end else begin
                        a_reg <= dp_quotient;
                        r_reg <= dp_remainder;
                        cnt   <= cnt + 4'd1;
                        if (cnt == LastStep) begin
                            lo       <= dp_quotient;
                            hi       <= dp_remainder;
                            div_zero <= zero_pend;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            state    <= StIdle;
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
